// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 mouse interface: init FSM states,
// protocol constants, default screen limits and the packet header layout.
package ps2_pkg;

    typedef enum logic [2:0] {
        ST_INHIBIT,
        ST_REQ,
        ST_TX,
        ST_ACK,
        ST_WAIT_FA,
        ST_STREAM
    } initState_t;

    // "Enable data reporting" command and the device acknowledge byte
    localparam logic [7:0] CMD_ENABLE = 8'hF4;
    localparam logic       CMD_PARITY = ~^CMD_ENABLE;
    localparam logic [7:0] RESP_ACK   = 8'hFA;

    localparam int DEFAULT_X_MAX  = 639;
    localparam int DEFAULT_Y_MAX  = 479;
    localparam int DEFAULT_X_INIT = 320;
    localparam int DEFAULT_Y_INIT = 240;

    // Fields of packet byte 0 that the decoder actually uses
    typedef struct packed {
        logic yOvf;
        logic xOvf;
        logic ySign;
        logic xSign;
        logic left;
    } pktHeader_t;

    // Saturate a signed coordinate into 0..limit
    function automatic logic [9:0] clampAxis(input logic signed [11:0] value, input int limit);
        if (value < 0) begin
            return '0;
        end else if (int'(value) > limit) begin
            return 10'(limit);
        end else begin
            return value[9:0];
        end
    endfunction

endpackage

// File: rtl/ps2_rx_byte.sv
// PS/2 device-to-host frame receiver. Synchronizes both lines, detects
// falling edges of ps2 clock, shifts in start/8 data/parity/stop and flags
// good bytes or framing errors (including a mid-frame stall).
module ps2_rx_byte
    import ps2_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic       ps2ClkIn,
    input  logic       ps2DataIn,
    output logic       fallEdge,
    output logic       dataSync,
    output logic [7:0] rx_byte,
    output logic       byte_valid,
    output logic       frame_err
);

    localparam int GAP_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [1:0]       clkSync;
    logic [1:0]       dataSyncReg;
    logic             clkPrev;
    logic [3:0]       bitCount;
    logic [7:0]       shiftReg;
    logic             parityBit;
    logic [GAP_W-1:0] gapCount;

    assign fallEdge = clkPrev & ~clkSync[1];
    assign dataSync = dataSyncReg[1];

    // Two-flop synchronizers on both lines plus the previous clock sample for edge detection
    always_ff @(posedge clk) begin
        if (reset) begin
            clkSync     <= 2'b11;
            dataSyncReg <= 2'b11;
            clkPrev     <= 1'b1;
        end else begin
            clkSync     <= {clkSync[0], ps2ClkIn};
            dataSyncReg <= {dataSyncReg[0], ps2DataIn};
            clkPrev     <= clkSync[1];
        end
    end

    // Frame shifter: bit 0 start, 1..8 data LSB first, 9 parity, 10 stop; a stall mid-frame aborts it
    always_ff @(posedge clk) begin
        if (reset) begin
            bitCount   <= '0;
            shiftReg   <= '0;
            parityBit  <= 1'b0;
            gapCount   <= '0;
            rx_byte    <= '0;
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
            if (!enable) begin
                bitCount <= '0;
                gapCount <= '0;
            end else if (fallEdge) begin
                gapCount <= '0;
                if (bitCount == 4'd0) begin
                    if (!dataSync) begin
                        bitCount <= 4'd1;
                    end else begin
                        frame_err <= 1'b1;
                    end
                end else if (bitCount <= 4'd8) begin
                    shiftReg <= {dataSync, shiftReg[7:1]};
                    bitCount <= bitCount + 4'd1;
                end else if (bitCount == 4'd9) begin
                    parityBit <= dataSync;
                    bitCount  <= 4'd10;
                end else begin
                    bitCount <= '0;
                    if (dataSync && (^{shiftReg, parityBit})) begin
                        rx_byte    <= shiftReg;
                        byte_valid <= 1'b1;
                    end else begin
                        frame_err <= 1'b1;
                    end
                end
            end else if (bitCount != 4'd0) begin
                if (gapCount == GAP_W'(TIMEOUT_CYCLES - 1)) begin
                    bitCount  <= '0;
                    gapCount  <= '0;
                    frame_err <= 1'b1;
                end else begin
                    gapCount <= gapCount + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/ps2_mouse.sv
// PS/2 mouse host: sends the enable-reporting command after reset, waits
// for the acknowledge, then decodes 3-byte stream packets into a clamped
// cursor position and left-button state.
module ps2_mouse
    import ps2_pkg::*;
#(
    parameter int INHIBIT_CYCLES = 5000,
    parameter int TIMEOUT_CYCLES = 50000,
    parameter int X_MAX          = DEFAULT_X_MAX,
    parameter int Y_MAX          = DEFAULT_Y_MAX,
    parameter int X_INIT         = DEFAULT_X_INIT,
    parameter int Y_INIT         = DEFAULT_Y_INIT
) (
    input  logic       clk,
    input  logic       reset,
    inout  wire        ps2_clk,
    inout  wire        ps2_data,
    output logic [9:0] mouse_x,
    output logic [9:0] mouse_y,
    output logic       mouse_button,
    output logic       mouse_valid,
    output logic       init_done
);

    localparam int INIT_W = $clog2(INHIBIT_CYCLES + 1);
    localparam int GAP_W  = $clog2(TIMEOUT_CYCLES + 1);

    initState_t        state;
    logic [INIT_W-1:0] initCount;
    logic [GAP_W-1:0]  gapCount;
    logic [3:0]        txIdx;
    logic              clkLow;
    logic              dataLow;

    logic              rxEnable;
    logic              fallEdge;
    logic              dataSync;
    logic [7:0]        rxByte;
    logic              rxValid;
    logic              rxErr;

    logic [1:0]        byteIdx;
    pktHeader_t        header;
    logic [7:0]        byte1Reg;
    logic signed [11:0] dx;
    logic signed [11:0] dy;
    logic signed [11:0] xSum;
    logic signed [11:0] ySum;

    // Open-drain: only ever pull low or float
    assign ps2_clk  = clkLow  ? 1'b0 : 1'bz;
    assign ps2_data = dataLow ? 1'b0 : 1'bz;

    assign rxEnable = (state == ST_WAIT_FA) || (state == ST_STREAM);

    ps2_rx_byte #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) rxByteInst (
        .clk       (clk),
        .reset     (reset),
        .enable    (rxEnable),
        .ps2ClkIn  (ps2_clk),
        .ps2DataIn (ps2_data),
        .fallEdge  (fallEdge),
        .dataSync  (dataSync),
        .rx_byte   (rxByte),
        .byte_valid(rxValid),
        .frame_err (rxErr)
    );

    // Init sequence: inhibit, request-to-send, clock out 0xF4, check ACK bit, wait for 0xFA, then stream
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_INHIBIT;
            initCount <= '0;
            gapCount  <= '0;
            txIdx     <= '0;
            clkLow    <= 1'b0;
            dataLow   <= 1'b0;
            init_done <= 1'b0;
        end else begin
            case (state)
                ST_INHIBIT: begin
                    clkLow   <= 1'b1;
                    dataLow  <= 1'b0;
                    gapCount <= '0;
                    txIdx    <= '0;
                    if (initCount == INIT_W'(INHIBIT_CYCLES - 1)) begin
                        initCount <= '0;
                        dataLow   <= 1'b1;
                        state     <= ST_REQ;
                    end else begin
                        initCount <= initCount + 1'b1;
                    end
                end
                ST_REQ: begin
                    clkLow <= 1'b0;
                    state  <= ST_TX;
                end
                ST_TX: begin
                    if (fallEdge) begin
                        gapCount <= '0;
                        if (txIdx < 4'd8) begin
                            dataLow <= ~CMD_ENABLE[txIdx[2:0]];
                            txIdx   <= txIdx + 4'd1;
                        end else if (txIdx == 4'd8) begin
                            dataLow <= ~CMD_PARITY;
                            txIdx   <= 4'd9;
                        end else begin
                            dataLow <= 1'b0;
                            state   <= ST_ACK;
                        end
                    end else if (gapCount == GAP_W'(TIMEOUT_CYCLES - 1)) begin
                        dataLow   <= 1'b0;
                        initCount <= '0;
                        state     <= ST_INHIBIT;
                    end else begin
                        gapCount <= gapCount + 1'b1;
                    end
                end
                ST_ACK: begin
                    if (fallEdge) begin
                        gapCount <= '0;
                        state    <= dataSync ? ST_INHIBIT : ST_WAIT_FA;
                    end else if (gapCount == GAP_W'(TIMEOUT_CYCLES - 1)) begin
                        initCount <= '0;
                        state     <= ST_INHIBIT;
                    end else begin
                        gapCount <= gapCount + 1'b1;
                    end
                end
                ST_WAIT_FA: begin
                    if (rxValid) begin
                        if (rxByte == RESP_ACK) begin
                            init_done <= 1'b1;
                            state     <= ST_STREAM;
                        end else begin
                            initCount <= '0;
                            state     <= ST_INHIBIT;
                        end
                    end else if (rxErr) begin
                        initCount <= '0;
                        state     <= ST_INHIBIT;
                    end else if (fallEdge) begin
                        gapCount <= '0;
                    end else if (gapCount == GAP_W'(TIMEOUT_CYCLES - 1)) begin
                        initCount <= '0;
                        state     <= ST_INHIBIT;
                    end else begin
                        gapCount <= gapCount + 1'b1;
                    end
                end
                default: begin
                    clkLow  <= 1'b0;
                    dataLow <= 1'b0;
                end
            endcase
        end
    end

    // Candidate positions: 9-bit deltas sign-extended to 12 bits; Y is inverted so 0 stays at the top
    always_comb begin
        dx   = {{4{header.xSign}}, byte1Reg};
        dy   = {{4{header.ySign}}, rxByte};
        xSum = $signed({2'b00, mouse_x}) + dx;
        ySum = $signed({2'b00, mouse_y}) - dy;
    end

    // Packet assembly: byte 0 must carry bit3 as a sync marker; byte 2 commits the update
    always_ff @(posedge clk) begin
        if (reset) begin
            byteIdx      <= '0;
            header       <= '0;
            byte1Reg     <= '0;
            mouse_x      <= 10'(X_INIT);
            mouse_y      <= 10'(Y_INIT);
            mouse_button <= 1'b0;
            mouse_valid  <= 1'b0;
        end else begin
            mouse_valid <= 1'b0;
            if (state != ST_STREAM || rxErr) begin
                byteIdx <= '0;
            end else if (rxValid) begin
                case (byteIdx)
                    2'd0: begin
                        if (rxByte[3]) begin
                            header  <= '{yOvf: rxByte[7], xOvf: rxByte[6], ySign: rxByte[5],
                                         xSign: rxByte[4], left: rxByte[0]};
                            byteIdx <= 2'd1;
                        end
                    end
                    2'd1: begin
                        byte1Reg <= rxByte;
                        byteIdx  <= 2'd2;
                    end
                    default: begin
                        if (!header.xOvf) begin
                            mouse_x <= clampAxis(xSum, X_MAX);
                        end
                        if (!header.yOvf) begin
                            mouse_y <= clampAxis(ySum, Y_MAX);
                        end
                        mouse_button <= header.left;
                        mouse_valid  <= 1'b1;
                        byteIdx      <= 2'd0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ps2_mouse.sv
// Directed testbench for ps2_mouse with a behavioural PS/2 mouse model.
module tb_ps2_mouse;

    localparam int INHIBIT = 5000;
    localparam int TIMEOUT = 4000;
    localparam int HALF    = 15;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       devClkLow = 1'b0;
    logic       devDataLow = 1'b0;
    wire        ps2Clk;
    wire        ps2Data;
    logic [9:0] mouseX;
    logic [9:0] mouseY;
    logic       mouseButton;
    logic       mouseValid;
    logic       initDone;

    int errors = 0;
    int checks = 0;
    int validCount = 0;
    int v0;

    assign ps2Clk  = devClkLow  ? 1'b0 : 1'bz;
    assign ps2Data = devDataLow ? 1'b0 : 1'bz;
    pullup (ps2Clk);
    pullup (ps2Data);

    ps2_mouse #(
        .INHIBIT_CYCLES(INHIBIT),
        .TIMEOUT_CYCLES(TIMEOUT)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .ps2_clk     (ps2Clk),
        .ps2_data    (ps2Data),
        .mouse_x     (mouseX),
        .mouse_y     (mouseY),
        .mouse_button(mouseButton),
        .mouse_valid (mouseValid),
        .init_done   (initDone)
    );

    // System clock
    always #5 clk = ~clk;

    // Count every cycle mouse_valid is high, sampled away from the active edge
    always @(negedge clk) begin
        if (mouseValid === 1'b1) validCount++;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Device-to-host frame; bitsToSend < 11 leaves the frame stalled
    task automatic sendFrame(input logic [7:0] b, input logic flipParity, input int bitsToSend);
        logic [10:0] frame;
        frame = {1'b1, (~^b) ^ flipParity, b, 1'b0};
        for (int i = 0; i < bitsToSend; i++) begin
            devDataLow = ~frame[i];
            waitCycles(HALF);
            devClkLow = 1'b1;
            waitCycles(HALF);
            devClkLow = 1'b0;
        end
        devDataLow = 1'b0;
        waitCycles(2 * HALF);
    endtask

    task automatic applyStimulus(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
        sendFrame(b0, 1'b0, 11);
        sendFrame(b1, 1'b0, 11);
        sendFrame(b2, 1'b0, 11);
        waitCycles(5);
    endtask

    task automatic applyReset(input string tag);
        reset = 1'b1;
        waitCycles(5);
        checkOutput({tag, "_x"}, 32'(mouseX), 320);
        checkOutput({tag, "_y"}, 32'(mouseY), 240);
        checkOutput({tag, "_button"}, 32'(mouseButton), 0);
        checkOutput({tag, "_valid"}, 32'(mouseValid), 0);
        checkOutput({tag, "_initDone"}, 32'(initDone), 0);
        checkOutput({tag, "_clkReleased"}, 32'(ps2Clk), 1);
        checkOutput({tag, "_dataReleased"}, 32'(ps2Data), 1);
        reset = 1'b0;
    endtask

    // Host inhibit/request, device clocks in the command, ACKs it and answers 0xFA
    task automatic initSequence();
        int lowCycles;
        logic [7:0] cmd;
        logic par;
        logic stp;
        logic sample;
        lowCycles = 0;
        cmd = '0;
        par = 1'b1;
        stp = 1'b0;
        for (int w = 0; w < INHIBIT + 200; w++) begin
            @(negedge clk);
            if (ps2Clk === 1'b1 && ps2Data === 1'b0) break;
            if (ps2Clk === 1'b0) lowCycles++;
        end
        checkOutput("inhibitLowCycles", 32'(lowCycles), INHIBIT);
        checkOutput("requestSeen", 32'(ps2Clk === 1'b1 && ps2Data === 1'b0), 1);
        for (int k = 1; k <= 10; k++) begin
            waitCycles(HALF);
            devClkLow = 1'b1;
            waitCycles(HALF);
            sample = ps2Data;
            devClkLow = 1'b0;
            if (k <= 8) cmd[k-1] = sample;
            else if (k == 9) par = sample;
            else stp = sample;
        end
        waitCycles(HALF / 2);
        devDataLow = 1'b1;
        waitCycles(HALF);
        devClkLow = 1'b1;
        waitCycles(HALF);
        devClkLow = 1'b0;
        devDataLow = 1'b0;
        checkOutput("txCommand", 32'(cmd), 32'hF4);
        checkOutput("txParity", 32'(par), 0);
        checkOutput("txStop", 32'(stp), 1);
        waitCycles(2 * HALF);
        checkOutput("initDoneBeforeFA", 32'(initDone), 0);
        sendFrame(8'hFA, 1'b0, 11);
        waitCycles(5);
        checkOutput("initDone", 32'(initDone), 1);
        checkOutput("streamClkIdle", 32'(ps2Clk), 1);
        checkOutput("streamDataIdle", 32'(ps2Data), 1);
    endtask

    initial begin
        applyReset("reset1");
        initSequence();

        v0 = validCount;
        applyStimulus(8'h09, 8'h0A, 8'h05);
        checkOutput("move_x", 32'(mouseX), 330);
        checkOutput("move_y", 32'(mouseY), 235);
        checkOutput("move_button", 32'(mouseButton), 1);
        checkOutput("move_pulses", 32'(validCount - v0), 1);

        v0 = validCount;
        applyStimulus(8'h48, 8'h7F, 8'h01);
        checkOutput("xOvf_x", 32'(mouseX), 330);
        checkOutput("xOvf_y", 32'(mouseY), 234);
        checkOutput("xOvf_button", 32'(mouseButton), 0);
        checkOutput("xOvf_pulses", 32'(validCount - v0), 1);

        v0 = validCount;
        sendFrame(8'h08, 1'b0, 11);
        sendFrame(8'h05, 1'b1, 11);
        sendFrame(8'h00, 1'b0, 11);
        waitCycles(5);
        checkOutput("parityErr_pulses", 32'(validCount - v0), 0);
        checkOutput("parityErr_x", 32'(mouseX), 330);
        applyStimulus(8'h08, 8'h01, 8'h00);
        checkOutput("afterErr_x", 32'(mouseX), 331);
        checkOutput("afterErr_y", 32'(mouseY), 234);
        checkOutput("afterErr_pulses", 32'(validCount - v0), 1);

        v0 = validCount;
        sendFrame(8'h01, 1'b0, 11);
        applyStimulus(8'h08, 8'h03, 8'hFF);
        checkOutput("stray_x", 32'(mouseX), 334);
        checkOutput("stray_yClampLow", 32'(mouseY), 0);
        checkOutput("stray_pulses", 32'(validCount - v0), 1);

        v0 = validCount;
        sendFrame(8'h08, 1'b0, 5);
        waitCycles(TIMEOUT + 200);
        applyStimulus(8'h08, 8'h02, 8'h00);
        checkOutput("stall_x", 32'(mouseX), 336);
        checkOutput("stall_y", 32'(mouseY), 0);
        checkOutput("stall_pulses", 32'(validCount - v0), 1);

        sendFrame(8'h38, 1'b0, 5);
        applyReset("reset2");
        initSequence();

        applyStimulus(8'h38, 8'h00, 8'h00);
        checkOutput("clamp1_x", 32'(mouseX), 64);
        checkOutput("clamp1_y", 32'(mouseY), 479);
        applyStimulus(8'h38, 8'h00, 8'h00);
        checkOutput("clamp2_x", 32'(mouseX), 0);
        checkOutput("clamp2_y", 32'(mouseY), 479);
        checkOutput("clamp2_button", 32'(mouseButton), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ps2_mouse.md
PS2_MOUSE -- requirements
Module: ps2_mouse

Interface
REQ-001 SHALL have parameter INHIBIT_CYCLES, default 5000, clk cycles ps2_clk is held low before the host request (100 us at 50 MHz).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 50000, maximum clk cycles between ps2_clk falling edges inside a frame.
REQ-003 SHALL have parameters X_MAX = 639 and Y_MAX = 479 (clamp limits) and X_INIT = 320 and Y_INIT = 240 (reset position).
REQ-004 SHALL have port clk, input, 1, system clock; the only clock in the block.
REQ-005 SHALL have port reset, input, 1, synchronous, active-high.
REQ-006 SHALL have port ps2_clk, inout, 1, open-drain: drive 0 or Z, never 1.
REQ-007 SHALL have port ps2_data, inout, 1, open-drain: drive 0 or Z, never 1.
REQ-008 SHALL have port mouse_x, output, 10, cursor column, 0..X_MAX.
REQ-009 SHALL have port mouse_y, output, 10, cursor row, 0..Y_MAX; 0 is the top of the screen.
REQ-010 SHALL have port mouse_button, output, 1, left button state.
REQ-011 SHALL have port mouse_valid, output, 1, one-cycle pulse on each position or button update.
REQ-012 SHALL have port init_done, output, 1, high once stream mode is entered.

Function
REQ-013 SHALL pass ps2_clk and ps2_data through 2-FF synchronizers and act only on synchronized falling edges of ps2_clk.
REQ-014 SHALL run the init FSM through these states: INHIBIT (ps2_clk driven low for INHIBIT_CYCLES) -> REQ (data driven low, clk released) -> TX -> ACK -> WAIT_FA -> STREAM.
REQ-015 SHALL, in TX, present the next bit on ps2_data after each falling edge: 0xF4 LSB-first, then odd parity (0), then stop (release).
REQ-016 SHALL, in ACK, require ps2_data = 0 on the next falling edge; in WAIT_FA, require a received byte equal to 0xFA.
REQ-017 SHALL, on a missing acknowledge, a wrong byte in WAIT_FA, or a timeout in TX, ACK or WAIT_FA, restart at INHIBIT.
REQ-018 SHALL receive frames of start 0, 8 data bits LSB-first, odd parity and stop 1, sampling ps2_data on the falling edge.
REQ-019 SHALL discard a frame with a bad start bit, parity or stop bit, and reset the packet byte index to 0.
REQ-020 SHALL, when no edge arrives for TIMEOUT_CYCLES mid-frame, abort the frame and reset the byte index to 0.
REQ-021 SHALL accept byte 0 of a packet only if bit3 = 1; otherwise drop the byte and keep the index at 0.
REQ-022 SHALL decode byte 0 as: bit0 left, bit4 X sign, bit5 Y sign, bit6 X overflow, bit7 Y overflow.
REQ-023 SHALL form dx = {Xsign, byte1} and dy = {Ysign, byte2}, each 9-bit two's complement.
REQ-024 SHALL compute x' = clamp(x + dx, 0, X_MAX) and y' = clamp(y - dy, 0, Y_MAX) in 12-bit signed arithmetic.
REQ-025 SHALL, when an overflow bit is set, leave that axis unchanged while still updating the button.
REQ-026 SHALL register outputs one clk after the stop-bit edge of byte 2, with mouse_valid high for exactly that cycle.
REQ-027 SHALL ignore ps2_clk edges during INHIBIT and REQ.
REQ-028 SHALL never drive ps2_clk and ps2_data low in STREAM.

Reset
REQ-029 SHALL, on reset, set mouse_x = X_INIT, mouse_y = Y_INIT, mouse_button = 0, mouse_valid = 0, init_done = 0, byte index = 0 and FSM = INHIBIT.
REQ-030 SHALL, on reset asserted mid-frame or mid-TX, release both lines the next cycle and discard any partial data.

Structure
REQ-031 SHALL place the FSM state encodings, the 0xF4 and 0xFA constants, and the default clamp limits in shared package ps2_pkg.
REQ-032 SHALL implement frame reception (synchronizer, edge detect, shift, parity, timeout) in sub-module ps2_rx_byte, which outputs byte, byte_valid and frame_err.

Verification
REQ-033 SHALL cover: reset -> ps2_clk low for 5000 cycles, then data low; the device model captures 0xF4 with parity 0 and ACKs; after 0xFA, init_done = 1.
REQ-034 SHALL cover: from (320,240), packet 0x09,0x0A,0x05 -> x = 330, y = 235, button = 1, exactly one mouse_valid pulse.
REQ-035 SHALL cover clamping: packet 0x38,0x00,0x00 twice -> x = 64 then x = 0, and y = 479 both times.
REQ-036 SHALL cover: packet 0x48,0x7F,0x01 -> x unchanged, y decrements by 1, button = 0.
REQ-037 SHALL cover: a parity error in byte 1 -> no valid pulse; the next good packet 0x08,0x01,0x00 gives x + 1.
REQ-038 SHALL cover: a stray byte 0x01 -> dropped; a frame stalled after 5 bits for 50000 cycles -> aborted; the following packet decodes correctly.
